uart_prog_loader: RTL

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives 8N1 UART bytes on RXD, packs every four accepted
// bytes little-endian into a 32-bit word and writes it to consecutive
// instruction-memory addresses with a one-cycle mem_we strobe.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running XOR checksum
// output of every word written.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RXD,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              frame_err,
`ifdef LOADER_CHECKSUM_EN
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       checksum
`else
  output logic [ADDR_W:0]   words_loaded
`endif
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);

  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]  WORDS_MAX = (ADDR_W + 1)'(2 ** ADDR_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Synchronizer
  logic rx_meta_q;
  logic rxs_q;

  // Receive control
  logic [1:0]       state_q,    state_d;
  logic [TMR_W-1:0] timer_q,    timer_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             frame_err_q, frame_err_d;

  // Receive data (no reset needed: only consumed after being written)
  logic [7:0]       shift_q, shift_d;
  logic [23:0]      word_q,  word_d;
  logic [31:0]      wdata_q, wdata_d;

  // Write side
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W:0]   words_q, words_d;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rxs_q     <= rx_meta_q;
    end
  end

  // Receive FSM, byte assembly and write-address bookkeeping
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    frame_err_d = frame_err_q;
    shift_d     = shift_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    words_d     = words_q;

    // The address and count advance the cycle after the strobe, so mem_addr
    // stays valid for the whole strobe cycle. This runs independently of the
    // FSM, so a start bit in the strobe cycle is still received.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
      if (words_q != WORDS_MAX) begin
        words_d = words_q + (ADDR_W + 1)'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          timer_d = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        // Re-check the line mid start bit; a high level here was a glitch
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
          if (rxs_q) begin
            // The fourth byte goes straight into the write register
            case (byte_idx_q)
              2'd0:    word_d[7:0]   = shift_q;
              2'd1:    word_d[15:8]  = shift_q;
              2'd2:    word_d[23:16] = shift_q;
              default: begin
                wdata_d = {shift_q, word_q};
                we_d    = 1'b1;
              end
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            // Bad stop bit: drop this byte and any partly built word
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      byte_idx_q  <= '0;
      frame_err_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      frame_err_q <= frame_err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
    end
  end

  // Datapath registers, no reset
  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
    word_q  <= word_d;
    wdata_q <= wdata_d;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Fold each written word into the running checksum after its strobe
  always_comb begin
    checksum_d = checksum_q;
    if (we_q) begin
      checksum_d = checksum_q ^ wdata_q;
    end
  end

  // Checksum register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_err    = frame_err_q;
  assign words_loaded = words_q;

endmodule
